// File: rtl/fp_mul_pipeline.sv
// Pipelined fp32 multiplier: classify (S1), 24x24 multiply (S2), normalize/round/pack (S3).
// Define FP_MUL_OUT_REG_EN to add an output register after S3 (latency 4 instead of 3).
`timescale 1ns/1ps

module fp_mul_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_data_in,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  rounding_mode,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        valid_data_out
);

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;
  localparam logic [31:0] QUIET_BIT    = 32'h0040_0000;

  // ---------------------------------------------------------------- S1 comb
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        zero1, zero2, inf1, inf2, qnan1, qnan2, snan1, snan2;
  logic        s1_sign_next;
  logic [9:0]  s1_exp_next;
  logic [2:0]  s1_mode_next;
  logic        s1_special_next;
  logic [31:0] s1_spec_res_next;
  logic        s1_spec_inv_next;

  always_comb begin
    e1 = in1[30:23];
    e2 = in2[30:23];
    m1 = in1[22:0];
    m2 = in2[22:0];
    // exponent 0 covers both true zeros and flushed denorms
    zero1 = (e1 == 8'd0);
    zero2 = (e2 == 8'd0);
    inf1  = (e1 == 8'hFF) && (m1 == 23'd0);
    inf2  = (e2 == 8'hFF) && (m2 == 23'd0);
    qnan1 = (e1 == 8'hFF) && m1[22];
    qnan2 = (e2 == 8'hFF) && m2[22];
    snan1 = (e1 == 8'hFF) && !m1[22] && (m1 != 23'd0);
    snan2 = (e2 == 8'hFF) && !m2[22] && (m2 != 23'd0);

    s1_sign_next = in1[31] ^ in2[31];
    s1_exp_next  = {2'b00, e1} + {2'b00, e2} - 10'd127;
    s1_mode_next = (rounding_mode > RM_RMM) ? RM_RNE : rounding_mode;

    s1_special_next  = 1'b1;
    s1_spec_res_next = 32'd0;
    // any signalling NaN operand raises invalid, whichever NaN is returned
    s1_spec_inv_next = snan1 | snan2;
    if (qnan1) begin
      s1_spec_res_next = in1;
    end else if (qnan2) begin
      s1_spec_res_next = in2;
    end else if (snan1) begin
      s1_spec_res_next = in1 | QUIET_BIT;
    end else if (snan2) begin
      s1_spec_res_next = in2 | QUIET_BIT;
    end else if ((inf1 && zero2) || (zero1 && inf2)) begin
      s1_spec_res_next = QNAN_DEFAULT;
      s1_spec_inv_next = 1'b1;
    end else if (inf1 || inf2) begin
      s1_spec_res_next = {s1_sign_next, 8'hFF, 23'd0};
    end else if (zero1 || zero2) begin
      s1_spec_res_next = {s1_sign_next, 31'd0};
    end else begin
      s1_special_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------- S1 reg
  logic        s1_valid_reg, s1_sign_reg, s1_special_reg, s1_spec_inv_reg;
  logic [9:0]  s1_exp_reg;
  logic [22:0] s1_m1_reg, s1_m2_reg;
  logic [2:0]  s1_mode_reg;
  logic [31:0] s1_spec_res_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_sign_reg     <= 1'b0;
      s1_special_reg  <= 1'b0;
      s1_spec_inv_reg <= 1'b0;
      s1_exp_reg      <= 10'd0;
      s1_m1_reg       <= 23'd0;
      s1_m2_reg       <= 23'd0;
      s1_mode_reg     <= 3'd0;
      s1_spec_res_reg <= 32'd0;
    end else begin
      s1_valid_reg    <= valid_data_in;
      s1_sign_reg     <= s1_sign_next;
      s1_special_reg  <= s1_special_next;
      s1_spec_inv_reg <= s1_spec_inv_next;
      s1_exp_reg      <= s1_exp_next;
      s1_m1_reg       <= m1;
      s1_m2_reg       <= m2;
      s1_mode_reg     <= s1_mode_next;
      s1_spec_res_reg <= s1_spec_res_next;
    end
  end

  // ---------------------------------------------------------------- S2 reg
  logic        s2_valid_reg, s2_sign_reg, s2_special_reg, s2_spec_inv_reg;
  logic [9:0]  s2_exp_reg;
  logic [47:0] s2_prod_reg;
  logic [2:0]  s2_mode_reg;
  logic [31:0] s2_spec_res_reg;
  logic [47:0] s2_prod_next;

  assign s2_prod_next = {24'd0, 1'b1, s1_m1_reg} * {24'd0, 1'b1, s1_m2_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg    <= 1'b0;
      s2_sign_reg     <= 1'b0;
      s2_special_reg  <= 1'b0;
      s2_spec_inv_reg <= 1'b0;
      s2_exp_reg      <= 10'd0;
      s2_prod_reg     <= 48'd0;
      s2_mode_reg     <= 3'd0;
      s2_spec_res_reg <= 32'd0;
    end else begin
      s2_valid_reg    <= s1_valid_reg;
      s2_sign_reg     <= s1_sign_reg;
      s2_special_reg  <= s1_special_reg;
      s2_spec_inv_reg <= s1_spec_inv_reg;
      s2_exp_reg      <= s1_exp_reg;
      s2_prod_reg     <= s2_prod_next;
      s2_mode_reg     <= s1_mode_reg;
      s2_spec_res_reg <= s1_spec_res_reg;
    end
  end

  // ---------------------------------------------------------------- S3 comb
  logic               p47, guard, sticky, lsb, inc;
  logic [22:0]        mant, mant_f;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_n, exp_r;
  logic [31:0]        s3_res_next;
  logic               s3_of_next, s3_uf_next, s3_ix_next, s3_inv_next;

  always_comb begin
    p47    = s2_prod_reg[47];
    mant   = p47 ? s2_prod_reg[46:24] : s2_prod_reg[45:23];
    guard  = p47 ? s2_prod_reg[23]    : s2_prod_reg[22];
    sticky = p47 ? (|s2_prod_reg[22:0]) : (|s2_prod_reg[21:0]);
    lsb    = mant[0];
    exp_n  = $signed({s2_exp_reg[9], s2_exp_reg}) + $signed({10'd0, p47});

    case (s2_mode_reg)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & s2_sign_reg;
      RM_RUP:  inc = (guard | sticky) & ~s2_sign_reg;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase

    mant_r = {1'b0, mant} + {23'd0, inc};
    // a carry out of the mantissa means it rolled over to 1.0 x 2^(e+1)
    exp_r  = exp_n + $signed({10'd0, mant_r[23]});
    mant_f = mant_r[23] ? 23'd0 : mant_r[22:0];

    s3_res_next = {s2_sign_reg, exp_r[7:0], mant_f};
    s3_of_next  = 1'b0;
    s3_uf_next  = 1'b0;
    s3_ix_next  = guard | sticky;
    s3_inv_next = 1'b0;

    if (s2_special_reg) begin
      s3_res_next = s2_spec_res_reg;
      s3_ix_next  = 1'b0;
      s3_inv_next = s2_spec_inv_reg;
    end else if (exp_n <= 11'sd0) begin
      s3_res_next = {s2_sign_reg, 31'd0};
      s3_uf_next  = 1'b1;
      s3_ix_next  = 1'b1;
    end else if (exp_r >= 11'sd255) begin
      s3_of_next = 1'b1;
      s3_ix_next = 1'b1;
      case (s2_mode_reg)
        RM_RTZ:  s3_res_next = {s2_sign_reg, 31'h7F7F_FFFF};
        RM_RDN:  s3_res_next = s2_sign_reg ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        RM_RUP:  s3_res_next = s2_sign_reg ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: s3_res_next = {s2_sign_reg, 8'hFF, 23'd0};
      endcase
    end

    if (!s2_valid_reg) begin
      s3_of_next  = 1'b0;
      s3_uf_next  = 1'b0;
      s3_ix_next  = 1'b0;
      s3_inv_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------- S3 reg
  logic [31:0] s3_res_reg;
  logic        s3_of_reg, s3_uf_reg, s3_ix_reg, s3_inv_reg, s3_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_res_reg   <= 32'd0;
      s3_of_reg    <= 1'b0;
      s3_uf_reg    <= 1'b0;
      s3_ix_reg    <= 1'b0;
      s3_inv_reg   <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      s3_res_reg   <= s3_res_next;
      s3_of_reg    <= s3_of_next;
      s3_uf_reg    <= s3_uf_next;
      s3_ix_reg    <= s3_ix_next;
      s3_inv_reg   <= s3_inv_next;
      s3_valid_reg <= s2_valid_reg;
    end
  end

`ifdef FP_MUL_OUT_REG_EN
  logic [31:0] o_res_reg;
  logic        o_of_reg, o_uf_reg, o_ix_reg, o_inv_reg, o_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_res_reg   <= 32'd0;
      o_of_reg    <= 1'b0;
      o_uf_reg    <= 1'b0;
      o_ix_reg    <= 1'b0;
      o_inv_reg   <= 1'b0;
      o_valid_reg <= 1'b0;
    end else begin
      o_res_reg   <= s3_res_reg;
      o_of_reg    <= s3_of_reg;
      o_uf_reg    <= s3_uf_reg;
      o_ix_reg    <= s3_ix_reg;
      o_inv_reg   <= s3_inv_reg;
      o_valid_reg <= s3_valid_reg;
    end
  end

  assign out               = o_res_reg;
  assign overflow          = o_of_reg;
  assign underflow         = o_uf_reg;
  assign inexact           = o_ix_reg;
  assign invalid_operation = o_inv_reg;
  assign valid_data_out    = o_valid_reg;
`else
  assign out               = s3_res_reg;
  assign overflow          = s3_of_reg;
  assign underflow         = s3_uf_reg;
  assign inexact           = s3_ix_reg;
  assign invalid_operation = s3_inv_reg;
  assign valid_data_out    = s3_valid_reg;
`endif

endmodule

// File: tb/tb_fp_mul_pipeline.sv
// Scoreboard bench for fp_mul_pipeline: directed vectors with hand-computed results,
// checked by a monitor that also verifies per-transaction latency and reset flushing.
`timescale 1ns/1ps

module tb_fp_mul_pipeline;

`ifdef FP_MUL_OUT_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_data_in;
  logic [31:0] in1, in2;
  logic [2:0]  rounding_mode;
  logic [31:0] out;
  logic        overflow, underflow, inexact, invalid_operation, valid_data_out;

  fp_mul_pipeline dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .valid_data_in     (valid_data_in),
    .in1               (in1),
    .in2               (in2),
    .rounding_mode     (rounding_mode),
    .out               (out),
    .overflow          (overflow),
    .underflow         (underflow),
    .inexact           (inexact),
    .invalid_operation (invalid_operation),
    .valid_data_out    (valid_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;   // {overflow, underflow, inexact, invalid}
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  // Drive one operation at the current negedge and hold it for one cycle.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] res, input logic [3:0] flags);
    exp_t e;
    valid_data_in = 1'b1;
    in1           = a;
    in2           = b;
    rounding_mode = rm;
    e.res   = res;
    e.flags = flags;
    e.cyc   = cyc;
    e.name  = name;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_data_in = 1'b0;
    in1           = 32'hDEAD_BEEF;
    in2           = 32'h1234_5678;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cleared(input string name);
    checks += 2;
    if (out !== 32'd0) begin
      errors++;
      $display("FAIL %s_out: got %h, required 00000000", name, out);
    end
    if ({overflow, underflow, inexact, invalid_operation, valid_data_out} !== 5'd0) begin
      errors++;
      $display("FAIL %s_flags: got ov/uf/ix/inv/vld=%b, required 00000", name,
               {overflow, underflow, inexact, invalid_operation, valid_data_out});
    end
    $display("%-14s reset outputs out=%h flags=%b valid=%b", name, out,
             {overflow, underflow, inexact, invalid_operation}, valid_data_out);
  endtask

  // Monitor: every valid output pops one expected entry.
  initial begin
    exp_t e;
    logic [3:0] got_flags;
    forever begin
      @(negedge clk);
      if (valid_data_out === 1'b1) begin
        got_flags = {overflow, underflow, inexact, invalid_operation};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_data_out=1 out=%h, required no output", out);
        end else begin
          e = sb.pop_front();
          checks += 3;
          $display("%-14s out=%h flags=%b latency=%0d", e.name, out, got_flags, cyc - e.cyc);
          if (out !== e.res) begin
            errors++;
            $display("FAIL %s_out: got %h, required %h", e.name, out, e.res);
          end
          if (got_flags !== e.flags) begin
            errors++;
            $display("FAIL %s_flags: got %b, required %b", e.name, got_flags, e.flags);
          end
          if (cyc - e.cyc != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required %0d", e.name, cyc - e.cyc, LAT);
          end
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    valid_data_in = 1'b0;
    in1           = 32'd0;
    in2           = 32'd0;
    rounding_mode = 3'd0;
    repeat (2) @(negedge clk);
    check_cleared("init_reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic arithmetic and rounding
    issue("basic",      32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
    issue("rnd_rne",    32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 4'b0010);
    issue("rnd_rup",    32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 4'b0010);
    issue("rnd_rtz",    32'h3F800001, 32'h3F800001, RTZ, 32'h3F800002, 4'b0010);
    issue("rnd_mode5",  32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800002, 4'b0010);
    issue("neg_six",    32'hC0000000, 32'h40400000, RNE, 32'hC0C00000, 4'b0000);
    issue("p47_rne",    32'h3FFFFFFF, 32'h3FFFFFFF, RNE, 32'h407FFFFE, 4'b0010);
    issue("p47_rup",    32'h3FFFFFFF, 32'h3FFFFFFF, RUP, 32'h407FFFFF, 4'b0010);
    issue("p47_rmm",    32'h3FFFFFFF, 32'h3FFFFFFF, RMM, 32'h407FFFFE, 4'b0010);
    // overflow in each mode
    issue("ovf_rne",    32'h7F000000, 32'h40000000, RNE, 32'h7F800000, 4'b1010);
    issue("ovf_rtz",    32'h7F000000, 32'h40000000, RTZ, 32'h7F7FFFFF, 4'b1010);
    issue("ovf_neg_rup",32'hFF000000, 32'h40000000, RUP, 32'hFF7FFFFF, 4'b1010);
    issue("ovf_neg_rdn",32'hFF000000, 32'h40000000, RDN, 32'hFF800000, 4'b1010);
    issue("ovf_pos_rdn",32'h7F000000, 32'h40000000, RDN, 32'h7F7FFFFF, 4'b1010);
    issue("ovf_pos_rup",32'h7F000000, 32'h40000000, RUP, 32'h7F800000, 4'b1010);
    // underflow and flush-to-zero
    issue("unf",        32'h00800000, 32'h3F000000, RNE, 32'h00000000, 4'b0110);
    issue("unf_neg_rup",32'h80800000, 32'h3F000000, RUP, 32'h80000000, 4'b0110);
    issue("denorm",     32'h00000001, 32'h40000000, RNE, 32'h00000000, 4'b0000);
    // specials
    issue("inf_x_zero", 32'h7F800000, 32'h80000000, RNE, 32'h7FC00000, 4'b0001);
    issue("snan1",      32'h7F800001, 32'h3F800000, RNE, 32'h7FC00001, 4'b0001);
    issue("qnan_snan",  32'h7FC00005, 32'h7F800001, RNE, 32'h7FC00005, 4'b0001);
    issue("neg_inf",    32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 4'b0000);
    issue("qnan2",      32'h3F800000, 32'hFFC00000, RNE, 32'hFFC00000, 4'b0000);
    issue("neg_zero",   32'h00000000, 32'hC0000000, RNE, 32'h80000000, 4'b0000);
    idle(LAT + 2);

    // streaming with a one-cycle gap (latency check verifies the gap is preserved)
    issue("strm0",      32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
    issue("strm1",      32'h40000000, 32'h40000000, RNE, 32'h40800000, 4'b0000);
    issue("strm2",      32'h3F800000, 32'hBF800000, RNE, 32'hBF800000, 4'b0000);
    issue("strm3",      32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 4'b0010);
    idle(1);
    issue("strm4",      32'h40400000, 32'h40400000, RNE, 32'h41100000, 4'b0000);
    issue("strm5",      32'h7F000000, 32'h40000000, RTZ, 32'h7F7FFFFF, 4'b1010);
    idle(LAT + 2);

    // reset with two operations in flight
    issue("lost0",      32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
    issue("lost1",      32'h7F000000, 32'h40000000, RNE, 32'h7F800000, 4'b1010);
    valid_data_in = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_cleared("midrst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 4);
    issue("post_rst",   32'h3FC00000, 32'h40000000, RNE, 32'h40400000, 4'b0000);
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outputs still pending, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipeline.md
# fp_mul_pipeline

Pipelined IEEE-754 single-precision multiplier in the FP ALU, the multiply counterpart of the divide pipeline. It shares its operand classification, flush-to-zero policy, NaN rules, `fp_pkg` rounding-mode encodings and exception-flag set. It accepts one operation per cycle with no backpressure. Each result and its flags leave together with a `valid_data_out` pulse a fixed number of cycles later.

## Interface
- No parameters; latency is set by `FP_MUL_OUT_REG_EN` (see Configuration).
- `clk  in  1`: rising-edge clock.
- `rst_n  in  1`: reset, asynchronous, active-low. One clock; all state clears while low.
- `valid_data_in  in  1`: operands and mode are valid this cycle.
- `in1, in2  in  32`: fp32 operands.
- `rounding_mode  in  3`: `fp_pkg` encoding RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4. Values 5–7 are treated as RNE.
- `out  out  32`: fp32 product.
- `overflow, underflow, inexact, invalid_operation  out  1 each`: exception flags, aligned with `out`.
- `valid_data_out  out  1`: `out` and the flags are valid this cycle.

## Operation
- **S1 (classify):**
  - Decode each operand as zero, denorm, infinite, qNaN (mantissa[22]=1) or sNaN.
  - Denorm operands are flushed to a zero of the same sign. Flushing raises no flag.
  - Register the operands, mode, sign (`in1.sign ^ in2.sign`) and the 10-bit signed exponent `e1 + e2 - 127`.
  - Register the special-case flag and result. The first matching case wins:
    1. `in1` is qNaN: result `in1`.
    2. `in2` is qNaN: result `in2`.
    3. `in1` is sNaN: result `in1 | 0x00400000`, invalid=1.
    4. `in2` is sNaN: result `in2 | 0x00400000`, invalid=1.
    5. Infinity × zero, either order: result `0x7FC00000`, invalid=1.
    6. Either operand infinite: signed infinity.
    7. Either operand zero: signed zero. This case is exact, so no flags.
- **S2 (multiply):** register the 48-bit product `{1,m1} × {1,m2}`. Sign, exponent, special data and valid travel alongside it.
- **S3 (normalize, round, pack):**
  - If `p[47]`: mantissa `p[46:24]`, guard `p[23]`, sticky `|p[22:0]`, exponent +1.
  - Otherwise: mantissa `p[45:23]`, guard `p[22]`, sticky `|p[21:0]`.
  - Round increment by mode:
    - RNE: `g & (s | lsb)`.
    - RTZ: 0.
    - RDN: `(g|s) & sign`.
    - RUP: `(g|s) & ~sign`.
    - RMM: `g`.
  - A mantissa carry from rounding adds 1 to the exponent and zeroes the mantissa.
  - `inexact = g | s`.
- **Underflow:** tininess is detected before rounding. If the normalized exponent is ≤ 0, the result is a signed zero in every mode, with underflow=1 and inexact=1.
- **Overflow:** if the exponent after rounding is ≥ 255, overflow=1 and inexact=1. The result depends on mode:
  - RNE or RMM: signed infinity.
  - RTZ: signed `0x7F7FFFFF`.
  - RDN: +`0x7F7FFFFF` for a positive result, `0xFF800000` for a negative one.
  - RUP: `0x7F800000` for a positive result, −`0x7F7FFFFF` for a negative one.
- **Special results:** when the special-case flag is set, the S1 result and flags override the arithmetic path. Arithmetic flags are 0.
- **Flags:** meaningful only while `valid_data_out=1`. They are 0 whenever the output register is loaded with an invalid slot.

## Timing
- **Latency:** operands sampled at edge N appear with `valid_data_out=1` after edge N+3. With `FP_MUL_OUT_REG_EN` this becomes N+4.
- **Throughput:** one operation per cycle. Results stay in order, and gaps in `valid_data_in` reproduce as gaps in `valid_data_out`.
- **Valid handling:** every stage register loads every cycle. Valid bits follow the data, so an invalid slot leaves its data as don't-care with flags forced to 0.
- **Reset:**
  - While `rst_n=0`, every stage register and every output is 0: `out=0`, all flags 0, `valid_data_out=0`.
  - Asserting reset mid-stream discards every in-flight operation. None of them emerge after reset is released.
  - Operands presented on the first edge after release are processed normally.

## Configuration
- `FP_MUL_OUT_REG_EN` defined: an extra output register stage follows S3, latency 4, giving a cleaner timing path from the rounding logic to the outputs.
- Undefined: S3 drives the outputs directly, latency 3.
- Functional results are identical in both builds.

## Test plan
- **Basic product:** `0x3FC00000 × 0x40000000`, RNE → `0x40400000`, all flags 0, `valid_data_out` exactly 3 cycles after input (4 with the macro).
- **Rounding:** `0x3F800001 × 0x3F800001`:
  - RNE → `0x3F800002`, inexact=1.
  - RUP → `0x3F800003`.
  - RTZ → `0x3F800002`.
- **Overflow:** `0x7F000000 × 0x40000000`:
  - RNE → `0x7F800000`, overflow=1, inexact=1.
  - RTZ → `0x7F7FFFFF`.
  - Negating `in1`, RUP → `0xFF7FFFFF`.
- **Underflow and flush:** `0x00800000 × 0x3F000000` → `0x00000000`, underflow=1, inexact=1. Denorm `0x00000001 × 0x40000000` → `0x00000000`, no flags.
- **Specials:**
  - `0x7F800000 × 0x80000000` → `0x7FC00000`, invalid=1.
  - `0x7F800001 × 0x3F800000` → `0x7FC00001`, invalid=1.
  - `0x7FC00005 × 0x7F800001` → `0x7FC00005`, invalid=1.
  - `0xFF800000 × 0x40000000` → `0xFF800000`.
- **Streaming and reset:**
  - Issue 4 back-to-back operations, one idle cycle, then 2 more. Outputs must come out in order with the same one-cycle gap.
  - Drop `rst_n` with 2 operations in flight. All outputs read 0 immediately; no `valid_data_out` after release until new inputs arrive.
